// File: rtl/score_keeper_if.sv
// Signal bundle between the frame/collision logic and score_keeper.
// master drives frame events and start; slave (score_keeper) drives game status.
interface score_keeper_if;
  logic        frame_tick;
  logic        start;
  logic        bottle_hit;
  logic        shark_hit;
  logic [15:0] score_bcd;
  logic [2:0]  lives;
  logic [1:0]  game_state;
  logic        invuln;
  logic        game_over;
  logic        bottle_respawn;
  logic [15:0] hi_bcd;

  modport master (
    output frame_tick, start, bottle_hit, shark_hit,
    input  score_bcd, lives, game_state, invuln, game_over, bottle_respawn, hi_bcd
  );

  modport slave (
    input  frame_tick, start, bottle_hit, shark_hit,
    output score_bcd, lives, game_state, invuln, game_over, bottle_respawn, hi_bcd
  );
endinterface

// File: rtl/score_keeper.sv
// Game-rule stage: per-frame bottle/shark evaluation, BCD score, lives and IDLE/PLAY/HIT/OVER FSM.
// Optional HIGH_SCORE_EN builds a high-score register on hi_bcd; otherwise hi_bcd reads zero.
module score_keeper #(
  parameter int START_LIVES   = 3,
  parameter int HIT_COOLDOWN  = 64,
  parameter int BOTTLE_POINTS = 1
) (
  input  logic            clk,
  input  logic            rst,
  score_keeper_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_PLAY = 2'b01,
    S_HIT  = 2'b10,
    S_OVER = 2'b11
  } state_t;

  localparam logic [2:0] LP_LIVES  = 3'(START_LIVES);
  localparam logic [7:0] LP_COOL   = 8'(HIT_COOLDOWN);
  localparam logic [3:0] LP_POINTS = 4'(BOTTLE_POINTS);

  // Decimal-adjusted add; a carry out of the thousands digit saturates at 9999.
  function automatic logic [15:0] bcd_add(input logic [15:0] a, input logic [3:0] pts);
    logic [15:0] sum;
    logic [4:0]  d;
    logic        carry;
    sum   = '0;
    carry = 1'b0;
    for (int i = 0; i < 4; i++) begin
      d = {1'b0, a[4*i +: 4]} + ((i == 0) ? {1'b0, pts} : 5'd0) + {4'd0, carry};
      if (d > 5'd9) begin
        d     = d + 5'd6;
        carry = 1'b1;
      end else begin
        carry = 1'b0;
      end
      sum[4*i +: 4] = d[3:0];
    end
    return carry ? 16'h9999 : sum;
  endfunction

  state_t      r_state;
  logic [15:0] r_score;
  logic [2:0]  r_lives;
  logic [7:0]  r_cool;
  logic        r_b_flag;
  logic        r_s_flag;
  logic        r_invuln;
  logic        r_game_over;
  logic        r_respawn;

  state_t      w_state_next;
  logic [15:0] w_score_next;
  logic [2:0]  w_lives_next;
  logic [7:0]  w_cool_next;
  logic        w_respawn_next;
  logic        w_b_eff;
  logic        w_s_eff;
  logic        w_flags_clr;

  assign w_b_eff     = r_b_flag | bus.bottle_hit;
  assign w_s_eff     = r_s_flag | bus.shark_hit;
  assign w_flags_clr = bus.frame_tick | (r_state == S_IDLE) | (r_state == S_OVER);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch behind.
    w_state_next   = r_state;
    w_score_next   = r_score;
    w_lives_next   = r_lives;
    w_cool_next    = r_cool;
    w_respawn_next = 1'b0;
    case (r_state)
      S_IDLE, S_OVER: begin
        if (bus.start) begin
          w_state_next = S_PLAY;
          w_score_next = '0;
          w_lives_next = LP_LIVES;
          w_cool_next  = '0;
        end
      end
      S_PLAY, S_HIT: begin
        if (bus.frame_tick) begin
          if (w_b_eff) begin
            w_score_next   = bcd_add(r_score, LP_POINTS);
            w_respawn_next = 1'b1;
          end
          if (r_state == S_PLAY) begin
            if (w_s_eff) begin
              w_lives_next = r_lives - 3'd1;
              if (r_lives == 3'd1) begin
                w_state_next = S_OVER;
              end else begin
                w_state_next = S_HIT;
                w_cool_next  = LP_COOL;
              end
            end
          end else if (r_cool <= 8'd1) begin
            w_cool_next  = '0;
            w_state_next = S_PLAY;
          end else begin
            w_cool_next = r_cool - 8'd1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all update together at the edge.
    if (rst) begin
      r_state     <= S_IDLE;
      r_score     <= '0;
      r_lives     <= LP_LIVES;
      r_cool      <= '0;
      r_b_flag    <= 1'b0;
      r_s_flag    <= 1'b0;
      r_invuln    <= 1'b0;
      r_game_over <= 1'b0;
      r_respawn   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_score     <= w_score_next;
      r_lives     <= w_lives_next;
      r_cool      <= w_cool_next;
      r_b_flag    <= w_flags_clr ? 1'b0 : (r_b_flag | bus.bottle_hit);
      r_s_flag    <= w_flags_clr ? 1'b0 : (r_s_flag | bus.shark_hit);
      r_invuln    <= (w_state_next == S_HIT);
      r_game_over <= (w_state_next == S_OVER);
      r_respawn   <= w_respawn_next;
    end
  end

  assign bus.score_bcd      = r_score;
  assign bus.lives          = r_lives;
  assign bus.game_state     = r_state;
  assign bus.invuln         = r_invuln;
  assign bus.game_over      = r_game_over;
  assign bus.bottle_respawn = r_respawn;

`ifdef HIGH_SCORE_EN
  logic [15:0] r_hi;

  // Latched on the transition into OVER, using the score that game ends with.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi <= '0;
    end else if (w_state_next == S_OVER && r_state != S_OVER && w_score_next > r_hi) begin
      r_hi <= w_score_next;
    end
  end

  assign bus.hi_bcd = r_hi;
`else
  assign bus.hi_bcd = 16'h0000;
`endif

endmodule
